hazard_scoreboard: RTL and testbench

Parametrised hazard-control unit for the pipelined MIPS core. It tracks in-flight register writers in stages E through W internally, so the pipeline no longer hands it per-stage addresses. It generates the D-stage stall / E-stage bubble and the forwarding selects for the D- and E-stage operands. It owns the multiply/divide busy counter and the ERET-after-MTC0 interlock, and it sits beside the D/E pipeline registers.

---
 rtl/hazard_pkg.sv | 74 +++++++
 rtl/md_busy_ctr.sv | 46 ++++
 rtl/hazard_scoreboard.sv | 174 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: MD opcodes, CP0 EPC index,
// the in-flight entry layout and small helpers used by the select logic.
package hazard_pkg;

   // Multiply/divide unit opcodes carried with each instruction
   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MFHI  = 4'd5;
   localparam logic [3:0] MD_MFLO  = 4'd6;
   localparam logic [3:0] MD_MTHI  = 4'd7;
   localparam logic [3:0] MD_MTLO  = 4'd8;

   // Entry field widths; the top's AW/TW are zero-extended into these,
   // so AW and TW must not exceed them.
   localparam int ENT_AW = 8;
   localparam int ENT_TW = 8;

   // CP0 register number of EPC
   localparam logic [ENT_AW-1:0] CP0_EPC = 8'd14;

   typedef struct packed {
      logic              valid;
      logic [ENT_AW-1:0] a1;
      logic [ENT_AW-1:0] a2;
      logic [ENT_AW-1:0] a3;
      logic              rfen;
      logic [ENT_TW-1:0] tnew;
      logic [3:0]        md_op;
      logic              mtc0;
   } entry_t;

   localparam entry_t ENTRY_NULL = '{
      valid: 1'b0,
      a1:    {ENT_AW{1'b0}},
      a2:    {ENT_AW{1'b0}},
      a3:    {ENT_AW{1'b0}},
      rfen:  1'b0,
      tnew:  {ENT_TW{1'b0}},
      md_op: 4'd0,
      mtc0:  1'b0
   };

   // Width of a forwarding select able to name stages 0..nstage
   function automatic int sel_width(input int nstage);
      return $clog2(nstage + 1);
   endfunction

   // mult/multu/div/divu start the MD unit; mfhi..mtlo only use it
   function automatic logic is_md_start(input logic [3:0] op);
      return (op >= MD_MULT) && (op <= MD_DIVU);
   endfunction

   function automatic logic is_md_div(input logic [3:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // A live GPR write to a nonzero register equal to the requested source
   function automatic logic writes_reg(input entry_t e, input logic [ENT_AW-1:0] a);
      return e.valid && e.rfen && (e.a3 == a) && (a != {ENT_AW{1'b0}});
   endfunction

   // Tnew one stage later, saturating at zero
   function automatic logic [ENT_TW-1:0] tnew_age(input logic [ENT_TW-1:0] t);
      if (t == {ENT_TW{1'b0}}) begin
         return t;
      end else begin
         return t - {{(ENT_TW-1){1'b0}}, 1'b1};
      end
   endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Multiply/divide busy counter: loads the unit latency when an MD start
// leaves E (unless cancelled) and counts down to zero; busy while nonzero.
module md_busy_ctr
   import hazard_pkg::*;
#(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   input  logic cancel,
   output logic busy
);

   localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
   localparam int CW   = $clog2(MAXC + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: a fresh start reloads, otherwise count down toward zero
   always_comb begin
      cnt_d = cnt_q;
      if (start && !cancel) begin
         cnt_d = is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
      end else if (cnt_q != {CW{1'b0}}) begin
         cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register, cleared asynchronously by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy = (cnt_q != {CW{1'b0}});

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard-control unit: tracks in-flight writers in stages E..W, raises the
// D-stage stall, and produces forwarding selects for D and E operands.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter  int NSTAGE   = 3,
   parameter  int AW       = 5,
   parameter  int TW       = 3,
   parameter  int MULT_CYC = 5,
   parameter  int DIV_CYC  = 10,
   localparam int SW       = sel_width(NSTAGE)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] a1_d,
   input  logic [AW-1:0] a2_d,
   input  logic [TW-1:0] rs_tuse_d,
   input  logic [TW-1:0] rt_tuse_d,
   input  logic [AW-1:0] a3_d,
   input  logic          rfen_d,
   input  logic [TW-1:0] tnew_d,
   input  logic [3:0]    md_op_d,
   input  logic          mtc0_d,
   input  logic          eret_d,
   input  logic          flush,
   output logic          stall,
   output logic          md_busy,
   output logic [SW-1:0] fwd_d1_sel,
   output logic [SW-1:0] fwd_d2_sel,
   output logic [SW-1:0] fwd_e1_sel,
   output logic [SW-1:0] fwd_e2_sel
);

   entry_t ent_q [1:NSTAGE];
   entry_t ent_d [1:NSTAGE];
   entry_t d_ent_s;

   logic [NSTAGE:1] m_d1_s, m_d2_s, m_e1_s, m_e2_s;
   logic [NSTAGE:1] lt_d1_s, lt_d2_s, rdy_s, cp0w_s;
   logic [SW:0]     pk_d1_s, pk_d2_s, pk_e1_s, pk_e2_s;
   logic            stall_md_s, stall_eret_s, stall_s;
   logic            md_start_s, md_is_div_s, md_busy_s;

   // Youngest matching stage decides: {stall, select}
   function automatic logic [SW:0] pick_src(input logic [NSTAGE:1] match,
                                            input logic [NSTAGE:1] too_early,
                                            input logic [NSTAGE:1] ready);
      logic [SW:0] res;
      res = {(SW+1){1'b0}};
      for (int k = NSTAGE; k >= 1; k--) begin
         if (match[k]) begin
            if (too_early[k]) begin
               res = {1'b1, {SW{1'b0}}};
            end else if (ready[k]) begin
               res = {1'b0, SW'(k)};
            end else begin
               res = {(SW+1){1'b0}};
            end
         end
      end
      return res;
   endfunction

   // Pack the D instruction into an entry, widening address and Tnew fields
   always_comb begin
      d_ent_s       = ENTRY_NULL;
      d_ent_s.valid = 1'b1;
      d_ent_s.a1    = ENT_AW'(a1_d);
      d_ent_s.a2    = ENT_AW'(a2_d);
      d_ent_s.a3    = ENT_AW'(a3_d);
      d_ent_s.rfen  = rfen_d;
      d_ent_s.tnew  = ENT_TW'(tnew_d);
      d_ent_s.md_op = md_op_d;
      d_ent_s.mtc0  = mtc0_d;
   end

   generate
      for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
         entry_t nxt_s;

         assign m_d1_s[k]  = writes_reg(ent_q[k], ENT_AW'(a1_d));
         assign m_d2_s[k]  = writes_reg(ent_q[k], ENT_AW'(a2_d));
         assign lt_d1_s[k] = ENT_TW'(rs_tuse_d) < ent_q[k].tnew;
         assign lt_d2_s[k] = ENT_TW'(rt_tuse_d) < ent_q[k].tnew;
         assign rdy_s[k]   = (ent_q[k].tnew == {ENT_TW{1'b0}});

         if (k == 1) begin : g_head
            assign m_e1_s[k] = 1'b0;
            assign m_e2_s[k] = 1'b0;

            // E entry takes the D instruction unless stalled or flushed
            always_comb begin
               nxt_s = ENTRY_NULL;
               if (flush) begin
                  nxt_s = ENTRY_NULL;
               end else if (stall_s) begin
                  nxt_s = ENTRY_NULL;
               end else begin
                  nxt_s = d_ent_s;
               end
            end
         end else begin : g_tail
            assign m_e1_s[k] = ent_q[1].valid && writes_reg(ent_q[k], ent_q[1].a1);
            assign m_e2_s[k] = ent_q[1].valid && writes_reg(ent_q[k], ent_q[1].a2);

            // Later stages shift forward with Tnew aged by one cycle
            always_comb begin
               nxt_s = ENTRY_NULL;
               if (flush) begin
                  nxt_s = ENTRY_NULL;
               end else begin
                  nxt_s      = ent_q[k-1];
                  nxt_s.tnew = tnew_age(ent_q[k-1].tnew);
               end
            end
         end

         if (k < NSTAGE) begin : g_cp0
            assign cp0w_s[k] = ent_q[k].valid && ent_q[k].mtc0 && (ent_q[k].a3 == CP0_EPC);
         end else begin : g_cp0_last
            assign cp0w_s[k] = 1'b0;
         end

         assign ent_d[k] = nxt_s;
      end
   endgenerate

   assign md_start_s  = ent_q[1].valid && is_md_start(ent_q[1].md_op);
   assign md_is_div_s = is_md_div(ent_q[1].md_op);

   // Combine operand hazards with the MD and ERET interlocks
   always_comb begin
      pk_d1_s      = pick_src(m_d1_s, lt_d1_s, rdy_s);
      pk_d2_s      = pick_src(m_d2_s, lt_d2_s, rdy_s);
      pk_e1_s      = pick_src(m_e1_s, {NSTAGE{1'b0}}, rdy_s);
      pk_e2_s      = pick_src(m_e2_s, {NSTAGE{1'b0}}, rdy_s);
      stall_md_s   = (md_op_d != MD_NONE) && (md_start_s || md_busy_s);
      stall_eret_s = eret_d && (|cp0w_s);
      stall_s      = pk_d1_s[SW] | pk_d2_s[SW] | stall_md_s | stall_eret_s;
   end

   // Entry pipeline registers, cleared asynchronously by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 1; k <= NSTAGE; k++) begin
            ent_q[k] <= ENTRY_NULL;
         end
      end else begin
         for (int k = 1; k <= NSTAGE; k++) begin
            ent_q[k] <= ent_d[k];
         end
      end
   end

   md_busy_ctr #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_md_ctr (
      .clk    (clk),
      .reset  (reset),
      .start  (md_start_s),
      .is_div (md_is_div_s),
      .cancel (flush),
      .busy   (md_busy_s)
   );

   assign stall      = stall_s;
   assign md_busy    = md_busy_s;
   assign fwd_d1_sel = pk_d1_s[SW-1:0];
   assign fwd_d2_sel = pk_d2_s[SW-1:0];
   assign fwd_e1_sel = pk_e1_s[SW-1:0];
   assign fwd_e2_sel = pk_e2_s[SW-1:0];

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic, compared each cycle against a history-based reference model.
module tb_hazard_scoreboard;

   localparam int NSTAGE   = 3;
   localparam int AW       = 5;
   localparam int TW       = 3;
   localparam int MULT_CYC = 5;
   localparam int DIV_CYC  = 10;
   localparam int SW       = 2;
   localparam int NCYC     = 4000;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] a1_d, a2_d, a3_d;
   logic [TW-1:0] rs_tuse_d, rt_tuse_d, tnew_d;
   logic          rfen_d, mtc0_d, eret_d, flush;
   logic [3:0]    md_op_d;
   logic          stall, md_busy;
   logic [SW-1:0] fwd_d1_sel, fwd_d2_sel, fwd_e1_sel, fwd_e2_sel;

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .NSTAGE(NSTAGE), .AW(AW), .TW(TW), .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)
   ) dut (
      .clk(clk), .reset(reset),
      .a1_d(a1_d), .a2_d(a2_d), .rs_tuse_d(rs_tuse_d), .rt_tuse_d(rt_tuse_d),
      .a3_d(a3_d), .rfen_d(rfen_d), .tnew_d(tnew_d), .md_op_d(md_op_d),
      .mtc0_d(mtc0_d), .eret_d(eret_d), .flush(flush),
      .stall(stall), .md_busy(md_busy),
      .fwd_d1_sel(fwd_d1_sel), .fwd_d2_sel(fwd_d2_sel),
      .fwd_e1_sel(fwd_e1_sel), .fwd_e2_sel(fwd_e2_sel)
   );

   // Reference model: what D issued at each cycle; an instruction issued in
   // cycle c sits in stage k during cycle c+k unless a flush or reset intervened.
   typedef struct {
      bit v; int a1; int a2; int a3; bit rfen; int tnew; int md; bit mtc0;
   } rec_t;

   rec_t hist [0:NCYC-1];
   int   cyc, cyc_base, last_flush, md_end;
   int   n_checks, n_pass;
   bit   last_dut_stall, last_exp_stall, last_busy;
   int   last_fwd_d1, last_fwd_e1;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
   endtask

   function automatic bit st_valid(input int k);
      int idx;
      idx = cyc - k;
      return (idx >= cyc_base) && (idx > last_flush) && hist[idx].v;
   endfunction

   function automatic int tn(input int k);
      int t;
      t = hist[cyc-k].tnew - (k - 1);
      return (t < 0) ? 0 : t;
   endfunction

   task automatic ref_dsrc(input int a, input int tuse, output bit st, output int sel);
      st = 1'b0; sel = 0;
      if (a != 0) begin
         for (int k = 1; k <= NSTAGE; k++) begin
            if (st_valid(k) && hist[cyc-k].rfen && hist[cyc-k].a3 == a) begin
               if (tuse < tn(k)) st = 1'b1;
               else if (tn(k) == 0) sel = k;
               else sel = 0;
               break;
            end
         end
      end
   endtask

   task automatic ref_esrc(input int which, output int sel);
      int a;
      sel = 0;
      if (st_valid(1)) begin
         a = (which == 1) ? hist[cyc-1].a1 : hist[cyc-1].a2;
         if (a != 0) begin
            for (int k = 2; k <= NSTAGE; k++) begin
               if (st_valid(k) && hist[cyc-k].rfen && hist[cyc-k].a3 == a) begin
                  sel = (tn(k) == 0) ? k : 0;
                  break;
               end
            end
         end
      end
   endtask

   // One D-stage cycle: drive, check against the model, record, clock
   task automatic step(input int a1, input int a2, input int tu1, input int tu2,
                       input int a3, input bit rf, input int tnw, input int md,
                       input bit mt, input bit er, input bit fl);
      bit s1, s2, sm, se, st, busy, e_start;
      int d1, d2, e1, e2;
      a1_d = AW'(a1); a2_d = AW'(a2); a3_d = AW'(a3);
      rs_tuse_d = TW'(tu1); rt_tuse_d = TW'(tu2); tnew_d = TW'(tnw);
      rfen_d = rf; md_op_d = 4'(md); mtc0_d = mt; eret_d = er; flush = fl;
      #1;
      ref_dsrc(a1, tu1, s1, d1);
      ref_dsrc(a2, tu2, s2, d2);
      ref_esrc(1, e1);
      ref_esrc(2, e2);
      busy    = (cyc <= md_end);
      e_start = st_valid(1) && hist[cyc-1].md >= 1 && hist[cyc-1].md <= 4;
      sm      = (md != 0) && (e_start || busy);
      se      = 1'b0;
      for (int k = 1; k <= NSTAGE - 1; k++)
         if (st_valid(k) && hist[cyc-k].mtc0 && hist[cyc-k].a3 == 14) se = er;
      st = s1 | s2 | sm | se;
      check_eq("stall",   int'(stall),      int'(st));
      check_eq("md_busy", int'(md_busy),    int'(busy));
      check_eq("fwd_d1",  int'(fwd_d1_sel), d1);
      check_eq("fwd_d2",  int'(fwd_d2_sel), d2);
      check_eq("fwd_e1",  int'(fwd_e1_sel), e1);
      check_eq("fwd_e2",  int'(fwd_e2_sel), e2);
      last_dut_stall = stall; last_exp_stall = st; last_busy = md_busy;
      last_fwd_d1 = int'(fwd_d1_sel); last_fwd_e1 = int'(fwd_e1_sel);
      hist[cyc] = '{v: !st, a1: a1, a2: a2, a3: a3, rfen: rf, tnew: tnw, md: md, mtc0: mt};
      if (fl) last_flush = cyc;
      if (e_start && !fl) md_end = cyc + ((hist[cyc-1].md >= 3) ? DIV_CYC : MULT_CYC);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic nop();
      step(0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_zero_outputs(input string pfx);
      check_eq({pfx, "_stall"},   int'(stall),      0);
      check_eq({pfx, "_md_busy"}, int'(md_busy),    0);
      check_eq({pfx, "_fwd_d1"},  int'(fwd_d1_sel), 0);
      check_eq({pfx, "_fwd_d2"},  int'(fwd_d2_sel), 0);
      check_eq({pfx, "_fwd_e1"},  int'(fwd_e1_sel), 0);
      check_eq({pfx, "_fwd_e2"},  int'(fwd_e2_sel), 0);
   endtask

   initial begin
      int n_st;
      n_checks = 0; n_pass = 0;
      for (int i = 0; i < NCYC; i++) hist[i] = '{v: 1'b0, default: 0};
      cyc = 0; cyc_base = 0; last_flush = -1; md_end = -1;

      // Reset state: outputs all zero whatever D presents
      reset = 1'b1;
      a1_d = 5'd3; a2_d = 5'd3; a3_d = 5'd3; rs_tuse_d = 3'd0; rt_tuse_d = 3'd0;
      tnew_d = 3'd2; rfen_d = 1'b1; md_op_d = 4'd6; mtc0_d = 1'b1; eret_d = 1'b1; flush = 1'b0;
      #1;
      check_zero_outputs("rst");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Load-use: lw $3 (tnew 2) then addu reading $3 at tuse 0
      step(0, 0, 0, 0, 3, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
      n_st = 0;
      for (int i = 0; i < 8; i++) begin
         step(3, 0, 0, 3, 4, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
         if (last_dut_stall) n_st++;
         if (!last_exp_stall) break;
      end
      check_eq("lw_stall_cycles", n_st, 2);
      repeat (4) nop();

      // ALU chain: addu $5, nop, beq $5 -> forward from stage 2
      step(0, 0, 0, 0, 5, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
      nop();
      step(5, 0, 0, 3, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      check_eq("alu_chain_fwd_d1", last_fwd_d1, 2);
      check_eq("alu_chain_stall", int'(last_dut_stall), 0);
      repeat (4) nop();

      // Youngest wins: addu $7, ori $7, subu reading $7 in E
      step(0, 0, 0, 0, 7, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
      step(0, 0, 0, 0, 7, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
      step(7, 0, 1, 3, 8, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
      nop();
      check_eq("youngest_fwd_e1", last_fwd_e1, 2);
      repeat (4) nop();

      // $0 writer then $0 reader
      step(0, 0, 0, 0, 0, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
      step(0, 0, 0, 0, 1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      check_eq("zero_reg_stall", int'(last_dut_stall), 0);
      repeat (3) nop();

      // mult then mflo: stalls while mult in E plus MULT_CYC cycles
      step(1, 2, 0, 0, 0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);
      n_st = 0;
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 0, 0, 9, 1'b1, 1, 6, 1'b0, 1'b0, 1'b0);
         if (last_dut_stall) n_st++;
         if (!last_exp_stall) break;
      end
      check_eq("mult_mflo_stall_cycles", n_st, 1 + MULT_CYC);

      // div in E during a flush never starts the counter
      step(1, 2, 0, 0, 0, 1'b0, 0, 3, 1'b0, 1'b0, 1'b0);
      step(0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         nop();
         check_eq("div_flush_busy", int'(last_busy), 0);
      end

      // ERET after mtc0 $14: two stall cycles
      step(0, 0, 0, 0, 14, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      n_st = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
         if (last_dut_stall) n_st++;
         if (!last_exp_stall) break;
      end
      check_eq("eret_stall_cycles", n_st, 2);
      repeat (3) nop();

      // Flush while mtc0 is in M drops the interlock at the next edge
      step(0, 0, 0, 0, 14, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
      step(0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      step(0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
      check_eq("eret_stall_at_flush", int'(last_dut_stall), 1);
      step(0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      check_eq("eret_after_flush", int'(last_dut_stall), 0);
      repeat (3) nop();

      // Asynchronous reset while the MD counter runs
      step(1, 2, 0, 0, 0, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0);
      nop();
      nop();
      #2;
      reset = 1'b1;
      a1_d = 5'd1; rs_tuse_d = 3'd0; md_op_d = 4'd6; eret_d = 1'b1;
      #1;
      check_zero_outputs("arst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc_base = cyc; last_flush = cyc - 1; md_end = -1;

      // Random traffic over a small register set to provoke hazards
      for (int i = 0; i < 1500; i++) begin
         int md, a3;
         bit mt;
         mt = ($urandom_range(0, 9) == 0);
         a3 = mt ? 14 : int'($urandom_range(0, 3));
         md = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 8)) : 0;
         step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              a3, ($urandom_range(0, 3) != 0) && !mt, int'($urandom_range(0, 3)),
              md, mt, ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
